imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Upstream boot stage for the single-cycle core.
- Holds the core in reset and streams a program, one word per valid/ready handshake, into the instruction memory write port.
- After a flush delay, releases the core's active-low reset so execution starts from word 0.
- Used by the core-level benches and the array-sort demo to load programs without `$readmemh`.

Parameters:
- ADDR_WIDTH, 8, instruction-memory word-index width; depth = 2^ADDR_WIDTH words.
- DATA_WIDTH, 32, instruction word width.
- RELEASE_DELAY, 4, cycles between the last memory write and core reset release; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a load.
- word_count  input  ADDR_WIDTH+1  number of words to load; sampled only on an accepted start.
- in_valid  input  1  in_data is valid.
- in_data  input  DATA_WIDTH  program word.
- in_ready  output  1  loader accepts in_data this cycle.
- imem_we  output  1  instruction memory write enable.
- imem_addr  output  ADDR_WIDTH  word index to write.
- imem_wdata  output  DATA_WIDTH  word to write.
- core_rst  output  1  active-low reset to the core; 0 holds the core in reset.
- busy  output  1  high in LOAD or FLUSH.
- done  output  1  high in RUN.
- err  output  1  sticky bad-length flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE.
  - in_ready, imem_we, imem_addr, imem_wdata, busy, done, err = 0.
  - core_rst = 0.
  - Reset mid-LOAD or mid-FLUSH aborts immediately; memory contents are then partial/undefined and the core stays in reset.
- All outputs are registered; in_ready is decoded from registered state.
- IDLE:
  - in_ready = 0; core_rst = 0.
  - On start, if word_count == 0 or word_count > 2^ADDR_WIDTH: set err = 1 and remain in IDLE.
  - On start with a legal count: clear err, latch count, set write pointer = 0, go to LOAD.
- LOAD:
  - in_ready = 1; busy = 1.
  - Handshake = in_valid & in_ready.
  - On a handshake, next cycle: imem_we = 1, imem_addr = pointer, imem_wdata = in_data; pointer increments. Write latency is 1 cycle after the handshake.
  - Cycles without a handshake give imem_we = 0. Back-to-back handshakes give one write per cycle.
  - On the handshake of the final word (pointer == count-1):
    - Go to FLUSH; in_ready drops the following cycle, so no extra word is accepted.
    - Load the delay counter with RELEASE_DELAY.
    - That final write still issues in the next cycle.
  - The pointer never wraps. count == 2^ADDR_WIDTH ends at index 2^ADDR_WIDTH-1.
  - start is ignored in LOAD and FLUSH.
- FLUSH:
  - busy = 1; core_rst = 0.
  - Counter decrements each cycle; at 0, go to RUN.
  - Exactly RELEASE_DELAY cycles elapse between the final imem_we pulse and core_rst rising.
- RUN:
  - core_rst = 1; done = 1; busy = 0.
  - start with a legal count: core_rst = 0 and done = 0 on the next edge; reload begins (go to LOAD).
  - start with an illegal count: set err, force core_rst = 0, go to IDLE.
- Simultaneous start and in_valid in IDLE: no word is accepted in that cycle; the first acceptance can occur in the next cycle.
- err is cleared only by rst or by a start with a legal count.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, LOAD=2'd1, FLUSH=2'd2, RUN=2'd3;
  - default ADDR_WIDTH and DATA_WIDTH, shared with the instruction memory.
- No sub-module. The FSM, write pointer and delay counter stay in one module.
- A top-level wrapper instantiates the loader, the instruction memory (with an added write port) and the core, with core_rst driving the core's rst.

Test Plan:
- rst=0 held 3 cycles, then released → core_rst=0, in_ready=0, done=0, err=0 throughout; state IDLE.
- start with word_count=4; feed 0x00500293, 0x00A00313, 0x006283B3, 0x0000006F, back-to-back → imem_we high 4 consecutive cycles, addresses 0..3, data in order; in_ready low after 4th handshake; core_rst rises exactly 4 cycles after the last write; done=1.
- Same 4-word load with in_valid low on alternate cycles → 4 writes at addresses 0..3, no duplicates or gaps in address; release timing unchanged relative to the last write.
- start with word_count=0, then word_count=257 (ADDR_WIDTH=8) → err=1, remains IDLE, in_ready=0; then start with word_count=1 → err clears and LOAD is entered.
- Assert rst=0 after 2 of 4 words are accepted → all outputs return to reset values asynchronously; the next start with word_count=4 writes from address 0.
- In RUN, pulse start with word_count=2 → core_rst=0 next cycle, 2 writes at addresses 0..1, core_rst=1 again after RELEASE_DELAY.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: state encoding
// and the default memory geometry also used by the instruction memory.
package imem_boot_loader_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 8;
  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    RUN   = 2'd3
  } state_t;

endpackage

// File: rtl/imem_boot_loader.sv
// Boot loader: holds the core in reset, streams a program into instruction
// memory over a valid/ready handshake, then releases the core after a delay.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int RELEASE_DELAY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  core_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [ADDR_WIDTH:0] MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE       = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [3:0]          DELAY_INIT = 4'(RELEASE_DELAY);

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [3:0]            delay;

  logic count_ok;
  logic handshake;
  logic last_word;

  assign count_ok  = (word_count != '0) && (word_count <= MAX_COUNT);
  assign in_ready  = (state == LOAD);
  assign handshake = in_valid && in_ready;
  assign last_word = ({1'b0, ptr} == (count - ONE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ptr        <= '0;
      count      <= '0;
      delay      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (count_ok) begin
              err   <= 1'b0;
              count <= word_count;
              ptr   <= '0;
              busy  <= 1'b1;
              state <= LOAD;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (handshake) begin
            imem_we    <= 1'b1;
            imem_addr  <= ptr;
            imem_wdata <= in_data;
            // The pointer stops at the last index so a full-depth load never wraps.
            if (last_word) begin
              delay <= DELAY_INIT;
              state <= FLUSH;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        FLUSH: begin
          // Release lands RELEASE_DELAY edges after the edge raising the final write.
          if (delay <= 4'd1) begin
            core_rst <= 1'b1;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= RUN;
          end else begin
            delay <= delay - 1'b1;
          end
        end
        RUN: begin
          if (start) begin
            core_rst <= 1'b0;
            done     <= 1'b0;
            if (count_ok) begin
              err   <= 1'b0;
              count <= word_count;
              ptr   <= '0;
              busy  <= 1'b1;
              state <= LOAD;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: start-legality table, fixed and
// randomized program loads, async abort and reload-from-RUN sequences.
module tb_imem_boot_loader;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   word_count = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_wdata;
  logic          core_rst;
  logic          busy;
  logic          done;
  logic          err;

  imem_boot_loader #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .RELEASE_DELAY(RD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .word_count(word_count),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .core_rst(core_rst),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] prog [256];

  typedef struct {
    logic [AW:0] wc;
    logic        exp_err;
    logic        exp_ready;
    logic        exp_busy;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 0);
    chk({tag, "_imem_we"}, 64'(imem_we), 0);
    chk({tag, "_imem_addr"}, 64'(imem_addr), 0);
    chk({tag, "_imem_wdata"}, 64'(imem_wdata), 0);
    chk({tag, "_core_rst"}, 64'(core_rst), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_err"}, 64'(err), 0);
  endtask

  // Reference behaviour: word i of prog lands at address i exactly once, in order,
  // and core_rst rises RD cycles after the final write appears.
  task automatic do_load(input int n, input int mode, input string tag);
    int sent, got, cyc, last_we, first_we, rel, extra_wr, extra_acc;
    bit want;
    sent = 0; got = 0; cyc = 0; last_we = -1; first_we = -1; rel = -1;
    extra_wr = 0; extra_acc = 0;
    @(negedge clk);
    start = 1'b1; word_count = (AW+1)'(n); in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_start_busy"}, 64'(busy), 1);
    chk({tag, "_start_ready"}, 64'(in_ready), 1);
    chk({tag, "_start_core_rst"}, 64'(core_rst), 0);
    chk({tag, "_start_done"}, 64'(done), 0);
    chk({tag, "_start_err"}, 64'(err), 0);
    while (rel < 0 && cyc < 4 * n + RD + 40) begin
      if (core_rst) begin
        rel = cyc;
      end else begin
        if (imem_we) begin
          if (got < n) begin
            chk($sformatf("%s_addr%0d", tag, got), 64'(imem_addr), 64'(got));
            chk($sformatf("%s_data%0d", tag, got), 64'(imem_wdata), 64'(prog[got]));
          end else begin
            extra_wr++;
          end
          if (first_we < 0) first_we = cyc;
          last_we = cyc;
          got++;
        end
        if (in_ready && sent >= n) extra_acc++;
        case (mode)
          0:       want = 1'b1;
          1:       want = (cyc % 2 == 0);
          default: want = ($urandom_range(0, 2) != 0);
        endcase
        if (sent >= n) begin
          in_valid = 1'b1;
          in_data  = $urandom;
        end else begin
          in_valid = want;
          in_data  = want ? prog[sent] : $urandom;
        end
        if (in_valid && in_ready && sent < n) sent++;
        @(negedge clk);
        cyc++;
      end
    end
    in_valid = 1'b0;
    chk({tag, "_released"}, 64'(rel >= 0), 1);
    chk({tag, "_write_count"}, 64'(got), 64'(n));
    chk({tag, "_extra_writes"}, 64'(extra_wr), 0);
    chk({tag, "_extra_accepts"}, 64'(extra_acc), 0);
    chk({tag, "_release_delay"}, 64'(rel - last_we), 64'(RD));
    if (mode == 0) chk({tag, "_b2b_span"}, 64'(last_we - first_we), 64'(n - 1));
    chk({tag, "_run_done"}, 64'(done), 1);
    chk({tag, "_run_busy"}, 64'(busy), 0);
    chk({tag, "_run_ready"}, 64'(in_ready), 0);
    chk({tag, "_run_err"}, 64'(err), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held three cycles, then released into IDLE.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset_outputs($sformatf("rst_hold%0d", i));
    end
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_idle");

    // Start legality table; start arrives together with in_valid, which must not write.
    vecs[0] = '{wc: 9'd0,   exp_err: 1'b1, exp_ready: 1'b0, exp_busy: 1'b0};
    vecs[1] = '{wc: 9'd1,   exp_err: 1'b0, exp_ready: 1'b1, exp_busy: 1'b1};
    vecs[2] = '{wc: 9'd257, exp_err: 1'b1, exp_ready: 1'b0, exp_busy: 1'b0};
    vecs[3] = '{wc: 9'd511, exp_err: 1'b1, exp_ready: 1'b0, exp_busy: 1'b0};
    vecs[4] = '{wc: 9'd0,   exp_err: 1'b1, exp_ready: 1'b0, exp_busy: 1'b0};
    vecs[5] = '{wc: 9'd256, exp_err: 1'b0, exp_ready: 1'b1, exp_busy: 1'b1};
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      start = 1'b1; word_count = vecs[v].wc; in_valid = 1'b1; in_data = $urandom;
      @(negedge clk);
      start = 1'b0; in_valid = 1'b0;
      chk($sformatf("vec%0d_err", v), 64'(err), 64'(vecs[v].exp_err));
      chk($sformatf("vec%0d_ready", v), 64'(in_ready), 64'(vecs[v].exp_ready));
      chk($sformatf("vec%0d_busy", v), 64'(busy), 64'(vecs[v].exp_busy));
      chk($sformatf("vec%0d_we", v), 64'(imem_we), 0);
      chk($sformatf("vec%0d_core_rst", v), 64'(core_rst), 0);
      if (vecs[v].exp_ready) begin
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
    end

    // Fixed four-word program, back-to-back and with alternate idle cycles.
    prog[0] = 32'h00500293; prog[1] = 32'h00A00313;
    prog[2] = 32'h006283B3; prog[3] = 32'h0000006F;
    do_load(4, 0, "prog_b2b");
    do_load(4, 1, "prog_alt");

    // Asynchronous abort after two accepted words, mid-cycle.
    rst = 1'b0; @(negedge clk); rst = 1'b1;
    @(negedge clk);
    start = 1'b1; word_count = 9'd4;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = prog[0];
    @(negedge clk);
    in_data = prog[1];
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_pre_we", 64'(imem_we), 1);
    #2 rst = 1'b0;
    #1 check_reset_outputs("abort_async");
    @(negedge clk);
    rst = 1'b1;
    do_load(4, 0, "after_abort");

    // Reload from RUN with two words.
    prog[0] = $urandom; prog[1] = $urandom;
    do_load(2, 0, "reload_run");

    // Illegal start from RUN drops to IDLE with err set and the core in reset.
    @(negedge clk);
    start = 1'b1; word_count = 9'd0;
    @(negedge clk);
    start = 1'b0;
    chk("run_bad_err", 64'(err), 1);
    chk("run_bad_core_rst", 64'(core_rst), 0);
    chk("run_bad_done", 64'(done), 0);
    chk("run_bad_busy", 64'(busy), 0);
    @(negedge clk);
    chk("run_bad_idle_ready", 64'(in_ready), 0);

    // Randomized programs, lengths and valid gaps.
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) prog[i] = $urandom;
      do_load(n, 2, $sformatf("rand%0d", r));
    end

    // Full-depth load ends at the last index without wrapping.
    for (int i = 0; i < 256; i++) prog[i] = $urandom;
    do_load(256, 0, "full_depth");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
